// File: rtl/exu_csr_m.sv
// Machine-mode CSR file for the execute unit: M-mode status/trap registers,
// vectored mtvec, counter inhibit and 64-bit cycle/instret/hpm counters.
module exu_csr_m #(
  parameter int unsigned HPM_NUM = 4,
  parameter logic [31:0] HART_ID = 32'h0,
  parameter logic [31:0] MIMPID  = 32'hc109,
  parameter bit          VEC_EN  = 1'b1
) (
  input  logic                                    clk,
  input  logic                                    rst_n,
  input  logic [1:0]                              csr_op,
  input  logic [11:0]                             csr_idx,
  input  logic [31:0]                             csr_src,
  input  logic                                    csr_src_zero,
  output logic [31:0]                             csr_rdat,
  output logic                                    csr_ill,
  input  logic                                    trap_ena,
  input  logic [31:0]                             trap_cause,
  input  logic [31:0]                             trap_tval,
  input  logic [31:0]                             epc_pc,
  input  logic                                    mret_ena,
  output logic [31:0]                             trap_pc,
  output logic [31:0]                             mret_pc,
  input  logic                                    ext_ip,
  input  logic                                    tmr_ip,
  input  logic                                    sft_ip,
  output logic                                    irq_req,
  input  logic                                    in_retr,
  input  logic [((HPM_NUM > 0) ? HPM_NUM : 1)-1:0] hpm_evt
);

  localparam int unsigned NCNT     = HPM_NUM + 3;
  localparam logic [63:0] HPM_BITS = ((64'd1 << HPM_NUM) - 64'd1) << 3;
  localparam logic [31:0] INH_MASK = 32'h5 | HPM_BITS[31:0];
  localparam logic [31:0] MISA_VAL = 32'h4000_0100;

  localparam logic [11:0] A_MSTATUS  = 12'h300;
  localparam logic [11:0] A_MISA     = 12'h301;
  localparam logic [11:0] A_MIE      = 12'h304;
  localparam logic [11:0] A_MTVEC    = 12'h305;
  localparam logic [11:0] A_MCNTINH  = 12'h320;
  localparam logic [11:0] A_MSCRATCH = 12'h340;
  localparam logic [11:0] A_MEPC     = 12'h341;
  localparam logic [11:0] A_MCAUSE   = 12'h342;
  localparam logic [11:0] A_MTVAL    = 12'h343;
  localparam logic [11:0] A_MIP      = 12'h344;
  localparam logic [11:0] A_MVENDOR  = 12'hf11;
  localparam logic [11:0] A_MARCH    = 12'hf12;
  localparam logic [11:0] A_MIMP     = 12'hf13;
  localparam logic [11:0] A_MHART    = 12'hf14;
  localparam logic [11:0] A_MCFGPTR  = 12'hf15;

  logic        st_mie_q, st_mie_d, st_mpie_q, st_mpie_d;
  logic [2:0]  mie_en_q, mie_en_d, mip_q, mip_d;
  logic [29:0] tvec_base_q, tvec_base_d;
  logic        tvec_mode_q, tvec_mode_d;
  logic [31:0] mscratch_q, mscratch_d, mcause_q, mcause_d, mtval_q, mtval_d;
  logic [31:0] inhibit_q, inhibit_d;
  logic [30:0] mepc_q, mepc_d;
  logic        irq_req_q, irq_req_d;
  logic [63:0] cnt_q [NCNT];
  logic [63:0] cnt_d [NCNT];

  logic            hit, wr_try, wr_en;
  logic [31:0]     rd_val, wdat;
  logic [NCNT-1:0] cnt_lo_hit, cnt_hi_hit, cnt_inc;

  // Address decode and old-value read mux
  always_comb begin
    hit        = 1'b1;
    rd_val     = 32'd0;
    cnt_lo_hit = '0;
    cnt_hi_hit = '0;
    case (csr_idx)
      A_MSTATUS:  rd_val = {19'd0, 2'b11, 3'd0, st_mpie_q, 3'd0, st_mie_q, 3'd0};
      A_MISA:     rd_val = MISA_VAL;
      A_MIE:      rd_val = {20'd0, mie_en_q[2], 3'd0, mie_en_q[1], 3'd0, mie_en_q[0], 3'd0};
      A_MTVEC:    rd_val = {tvec_base_q, 1'b0, tvec_mode_q};
      A_MCNTINH:  rd_val = inhibit_q;
      A_MSCRATCH: rd_val = mscratch_q;
      A_MEPC:     rd_val = {mepc_q, 1'b0};
      A_MCAUSE:   rd_val = mcause_q;
      A_MTVAL:    rd_val = mtval_q;
      A_MIP:      rd_val = {20'd0, mip_q[2], 3'd0, mip_q[1], 3'd0, mip_q[0], 3'd0};
      A_MVENDOR, A_MARCH, A_MCFGPTR: rd_val = 32'd0;
      A_MIMP:     rd_val = MIMPID;
      A_MHART:    rd_val = HART_ID;
      default: begin
        hit = 1'b0;
        for (int i = 0; i < NCNT; i++) begin
          if (i != 1 && csr_idx[4:0] == 5'(i)) begin
            if (csr_idx[11:5] == 7'h58) begin
              hit           = 1'b1;
              rd_val        = cnt_q[i][31:0];
              cnt_lo_hit[i] = 1'b1;
            end else if (csr_idx[11:5] == 7'h5c) begin
              hit           = 1'b1;
              rd_val        = cnt_q[i][63:32];
              cnt_hi_hit[i] = 1'b1;
            end
          end
        end
      end
    endcase
  end

  always_comb begin
    wr_try = (csr_op != 2'b00) && !(csr_op[1] && csr_src_zero);
    csr_ill = (csr_op != 2'b00) && (!hit || (csr_idx[11:10] == 2'b11 && wr_try));
    wr_en = wr_try && !csr_ill;
    case (csr_op)
      2'b10:   wdat = rd_val | csr_src;
      2'b11:   wdat = rd_val & ~csr_src;
      default: wdat = csr_src;
    endcase
    csr_rdat = (csr_op != 2'b00 && !csr_ill) ? rd_val : 32'd0;
  end

  always_comb begin
    cnt_inc    = '0;
    cnt_inc[0] = 1'b1;
    cnt_inc[2] = in_retr;
    for (int i = 0; i < HPM_NUM; i++) cnt_inc[3+i] = hpm_evt[i];
  end

  // Next state: CSR write, then mret, then trap (later assignment wins)
  always_comb begin
    st_mie_d    = st_mie_q;
    st_mpie_d   = st_mpie_q;
    mie_en_d    = mie_en_q;
    mip_d       = {ext_ip, tmr_ip, sft_ip};
    tvec_base_d = tvec_base_q;
    tvec_mode_d = tvec_mode_q;
    mscratch_d  = mscratch_q;
    mepc_d      = mepc_q;
    mcause_d    = mcause_q;
    mtval_d     = mtval_q;
    inhibit_d   = inhibit_q;
    irq_req_d   = st_mie_q & |(mip_q & mie_en_q);
    if (wr_en) begin
      case (csr_idx)
        A_MSTATUS: begin
          st_mie_d  = wdat[3];
          st_mpie_d = wdat[7];
        end
        A_MIE:      mie_en_d = {wdat[11], wdat[7], wdat[3]};
        A_MTVEC: begin
          tvec_base_d = wdat[31:2];
          if (wdat[1:0] == 2'b00) tvec_mode_d = 1'b0;
          else if (wdat[1:0] == 2'b01 && VEC_EN) tvec_mode_d = 1'b1;
        end
        A_MCNTINH:  inhibit_d  = wdat & INH_MASK;
        A_MSCRATCH: mscratch_d = wdat;
        A_MEPC:     mepc_d     = wdat[31:1];
        A_MCAUSE:   mcause_d   = wdat;
        A_MTVAL:    mtval_d    = wdat;
        default: ;
      endcase
    end
    if (mret_ena) begin
      st_mie_d  = st_mpie_q;
      st_mpie_d = 1'b1;
    end
    if (trap_ena) begin
      st_mpie_d = st_mie_q;
      st_mie_d  = 1'b0;
      mepc_d    = epc_pc[31:1];
      mcause_d  = trap_cause;
      mtval_d   = trap_tval;
    end
  end

  // A write to either half suppresses the counter increment that cycle
  always_comb begin
    for (int i = 0; i < NCNT; i++) begin
      cnt_d[i] = cnt_q[i];
      if (wr_en && cnt_lo_hit[i])      cnt_d[i] = {cnt_q[i][63:32], wdat};
      else if (wr_en && cnt_hi_hit[i]) cnt_d[i] = {wdat, cnt_q[i][31:0]};
      else if (cnt_inc[i] && !inhibit_q[i]) cnt_d[i] = cnt_q[i] + 64'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_mie_q    <= 1'b0;
      st_mpie_q   <= 1'b0;
      mie_en_q    <= 3'd0;
      mip_q       <= 3'd0;
      tvec_base_q <= 30'd0;
      tvec_mode_q <= 1'b0;
      mscratch_q  <= 32'd0;
      mepc_q      <= 31'd0;
      mcause_q    <= 32'd0;
      mtval_q     <= 32'd0;
      inhibit_q   <= 32'd0;
      irq_req_q   <= 1'b0;
      for (int i = 0; i < NCNT; i++) cnt_q[i] <= 64'd0;
    end else begin
      st_mie_q    <= st_mie_d;
      st_mpie_q   <= st_mpie_d;
      mie_en_q    <= mie_en_d;
      mip_q       <= mip_d;
      tvec_base_q <= tvec_base_d;
      tvec_mode_q <= tvec_mode_d;
      mscratch_q  <= mscratch_d;
      mepc_q      <= mepc_d;
      mcause_q    <= mcause_d;
      mtval_q     <= mtval_d;
      inhibit_q   <= inhibit_d;
      irq_req_q   <= irq_req_d;
      for (int i = 0; i < NCNT; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  assign trap_pc = {tvec_base_q, 2'b00} +
                   ((tvec_mode_q && trap_cause[31]) ? {25'd0, trap_cause[4:0], 2'b00} : 32'd0);
  assign mret_pc = {mepc_q, 1'b0};
  assign irq_req = irq_req_q;

endmodule

// File: tb/tb_exu_csr_m.sv
// Directed bench for exu_csr_m with hand-computed expectations.
module tb_exu_csr_m;

  logic        clk, rst_n;
  logic [1:0]  csr_op;
  logic [11:0] csr_idx;
  logic [31:0] csr_src;
  logic        csr_src_zero;
  logic [31:0] csr_rdat;
  logic        csr_ill;
  logic        trap_ena;
  logic [31:0] trap_cause, trap_tval, epc_pc;
  logic        mret_ena;
  logic [31:0] trap_pc, mret_pc;
  logic        ext_ip, tmr_ip, sft_ip, irq_req, in_retr;
  logic [3:0]  hpm_evt;

  int total = 0;
  int bad   = 0;

  localparam logic [1:0] OP_RW = 2'b01, OP_RS = 2'b10, OP_RC = 2'b11;

  exu_csr_m dut (
    .clk(clk), .rst_n(rst_n),
    .csr_op(csr_op), .csr_idx(csr_idx), .csr_src(csr_src), .csr_src_zero(csr_src_zero),
    .csr_rdat(csr_rdat), .csr_ill(csr_ill),
    .trap_ena(trap_ena), .trap_cause(trap_cause), .trap_tval(trap_tval), .epc_pc(epc_pc),
    .mret_ena(mret_ena), .trap_pc(trap_pc), .mret_pc(mret_pc),
    .ext_ip(ext_ip), .tmr_ip(tmr_ip), .sft_ip(sft_ip), .irq_req(irq_req),
    .in_retr(in_retr), .hpm_evt(hpm_evt)
  );

  initial clk = 1'b0;
  always #50 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drv(input logic [1:0] op, input logic [11:0] idx,
                     input logic [31:0] src, input logic zero);
    csr_op = op; csr_idx = idx; csr_src = src; csr_src_zero = zero;
  endtask

  // Side-effect-free read: RS with a zero source
  task automatic rd(input string tag, input logic [11:0] idx, input logic [31:0] exp);
    drv(OP_RS, idx, 32'd0, 1'b1);
    #1;
    chk(tag, csr_rdat, exp);
    csr_op = 2'b00;
  endtask

  initial begin
    rst_n = 1'b0;
    drv(2'b00, 12'd0, 32'd0, 1'b0);
    trap_ena = 0; trap_cause = 0; trap_tval = 0; epc_pc = 0; mret_ena = 0;
    ext_ip = 0; tmr_ip = 0; sft_ip = 0; in_retr = 0; hpm_evt = 4'd0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;
    chk("rst_irq", {31'd0, irq_req}, 32'd0);
    chk("rst_trap_pc", trap_pc, 32'd0);
    chk("rst_mret_pc", mret_pc, 32'd0);
    rd("rst_mstatus", 12'h300, 32'h1800);
    rd("rst_mcycle", 12'hb00, 32'd0);

    in_retr = 1'b1;
    repeat (3) step();
    in_retr = 1'b0;
    rd("minstret", 12'hb02, 32'd3);

    // Interrupt path
    drv(OP_RS, 12'h300, 32'h8, 1'b0);
    #1;
    chk("rs_mstatus_old", csr_rdat, 32'h1800);
    step();
    drv(OP_RW, 12'h304, 32'h800, 1'b0);
    step();
    csr_op = 2'b00;
    ext_ip = 1'b1;
    step();
    rd("mip", 12'h344, 32'h800);
    chk("irq_early", {31'd0, irq_req}, 32'd0);
    step();
    chk("irq_set", {31'd0, irq_req}, 32'd1);
    ext_ip = 1'b0;
    step();
    step();
    chk("irq_clr", {31'd0, irq_req}, 32'd0);

    // Vectored trap and mret
    drv(OP_RW, 12'h305, 32'h1001, 1'b0);
    step();
    csr_op = 2'b00;
    trap_ena = 1'b1; trap_cause = 32'h8000_0007; trap_tval = 32'h1234; epc_pc = 32'h2003;
    #1;
    chk("trap_pc_vec", trap_pc, 32'h101c);
    step();
    trap_ena = 1'b0;
    rd("trap_mstatus", 12'h300, 32'h1880);
    chk("trap_mret_pc", mret_pc, 32'h2002);
    rd("trap_mepc", 12'h341, 32'h2002);
    rd("trap_mcause", 12'h342, 32'h8000_0007);
    rd("trap_mtval", 12'h343, 32'h1234);
    trap_cause = 32'd2;
    #1;
    chk("trap_pc_exc", trap_pc, 32'h1000);
    mret_ena = 1'b1;
    step();
    mret_ena = 1'b0;
    rd("mret_mstatus", 12'h300, 32'h1888);
    chk("mret_pc", mret_pc, 32'h2002);
    rd("mtvec", 12'h305, 32'h1001);
    drv(OP_RW, 12'h305, 32'h2002, 1'b0);
    step();
    rd("mtvec_mode_keep", 12'h305, 32'h2001);

    // Counter carry and inhibit
    drv(OP_RW, 12'hb00, 32'hffff_ffff, 1'b0);
    step();
    drv(OP_RW, 12'hb80, 32'd0, 1'b0);
    step();
    csr_op = 2'b00;
    step();
    rd("carry_lo", 12'hb00, 32'd0);
    rd("carry_hi", 12'hb80, 32'd1);
    drv(OP_RS, 12'h320, 32'h1, 1'b0);
    #1;
    chk("inh_old", csr_rdat, 32'd0);
    step();
    drv(OP_RW, 12'hb00, 32'h100, 1'b0);
    step();
    csr_op = 2'b00;
    repeat (5) step();
    rd("inh_frozen", 12'hb00, 32'h100);
    rd("inh_hi", 12'hb80, 32'd1);
    drv(OP_RW, 12'h320, 32'hffff_ffff, 1'b0);
    step();
    rd("inh_mask", 12'h320, 32'h7d);
    drv(OP_RW, 12'h320, 32'd0, 1'b0);
    step();
    csr_op = 2'b00;

    // Illegal / read-only access
    drv(OP_RW, 12'hf11, 32'h5, 1'b0);
    #1;
    chk("ro_wr_ill", {31'd0, csr_ill}, 32'd1);
    chk("ro_wr_rdat", csr_rdat, 32'd0);
    step();
    drv(OP_RS, 12'h301, 32'd0, 1'b1);
    #1;
    chk("misa_rs_ill", {31'd0, csr_ill}, 32'd0);
    chk("misa_rs_rdat", csr_rdat, 32'h4000_0100);
    drv(OP_RW, 12'h301, 32'd0, 1'b0);
    #1;
    chk("misa_wr_ill", {31'd0, csr_ill}, 32'd0);
    step();
    rd("misa_keep", 12'h301, 32'h4000_0100);
    drv(OP_RC, 12'hf14, 32'd0, 1'b1);
    #1;
    chk("hartid_rc_ill", {31'd0, csr_ill}, 32'd0);
    rd("mimpid", 12'hf13, 32'h0000_c109);
    drv(OP_RS, 12'h7c0, 32'd0, 1'b1);
    #1;
    chk("unimpl_ill", {31'd0, csr_ill}, 32'd1);
    chk("unimpl_rdat", csr_rdat, 32'd0);
    drv(OP_RW, 12'h323, 32'd1, 1'b0);
    #1;
    chk("hpmevent_ill", {31'd0, csr_ill}, 32'd1);
    csr_op = 2'b00;

    // Same-cycle priority (mstatus enters with MIE=1, MPIE=1)
    trap_ena = 1'b1; trap_cause = 32'd5; trap_tval = 32'd0; epc_pc = 32'h3000;
    drv(OP_RW, 12'h341, 32'h500, 1'b0);
    step();
    trap_ena = 1'b0;
    rd("prio_mepc", 12'h341, 32'h3000);
    rd("prio_mstatus1", 12'h300, 32'h1880);
    trap_ena = 1'b1; epc_pc = 32'h3100;
    drv(OP_RW, 12'h340, 32'habcd, 1'b0);
    step();
    trap_ena = 1'b0;
    rd("prio_mscratch", 12'h340, 32'habcd);
    rd("prio_mepc2", 12'h341, 32'h3100);
    trap_ena = 1'b1; mret_ena = 1'b1; epc_pc = 32'h4001;
    step();
    trap_ena = 1'b0; mret_ena = 1'b0;
    rd("trap_mret_mstatus", 12'h300, 32'h1800);
    chk("trap_mret_pc2", mret_pc, 32'h4000);

    // HPM counters
    hpm_evt = 4'b0010;
    repeat (5) step();
    hpm_evt = 4'd0;
    rd("hpm4", 12'hb04, 32'd5);
    rd("hpm3", 12'hb03, 32'd0);
    drv(OP_RW, 12'hb04, 32'd9, 1'b0);
    hpm_evt = 4'b0010;
    step();
    csr_op = 2'b00;
    hpm_evt = 4'd0;
    rd("hpm4_wr", 12'hb04, 32'd9);
    rd("hpm4h", 12'hb84, 32'd0);
    drv(OP_RS, 12'hb07, 32'd0, 1'b1);
    #1;
    chk("hpm7_ill", {31'd0, csr_ill}, 32'd1);
    drv(OP_RS, 12'hb01, 32'd0, 1'b1);
    #1;
    chk("time_ill", {31'd0, csr_ill}, 32'd1);
    csr_op = 2'b00;

    // Asynchronous reset mid-cycle
    #10;
    rst_n = 1'b0;
    #1;
    chk("arst_mret_pc", mret_pc, 32'd0);
    chk("arst_trap_pc", trap_pc, 32'd0);
    step();
    rst_n = 1'b1;
    rd("arst_mscratch", 12'h340, 32'd0);
    rd("arst_hpm4", 12'hb04, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
